nv_nvdla_pdp_wdma_dat_pack: RTL

Downstream neighbour of the PDP core datapath. Accepts the 64-bit pooled output atoms (8 x int8) on the core's dp2wdma handshake and packs four atoms per 256-bit DMA write-data beat, with a per-lane mask and a last-beat flag. Tracks position in the output cube (width x height x 8-channel surfaces) to flush a partial beat at end of layer. Pulses layer-done after the final beat drains. Sits between the PDP core and the PDP write-DMA command/data arbiter.

---
 rtl/nv_nvdla_pdp_pkg.sv | 21 ++
 rtl/nv_nvdla_pdp_wdma_cube_cnt.sv | 54 +++++
 rtl/nv_nvdla_pdp_wdma_dat_pack.sv | 131 +++++++++++++
 3 files changed

// File: rtl/nv_nvdla_pdp_pkg.sv
// Shared PDP definitions: atom/beat geometry, write-data packer FSM states
// and the packed output beat record.
package nv_nvdla_pdp_pkg;

  localparam int ATOM_W = 64;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pdp_wdma_pack_state_e;

  typedef struct packed {
    logic [ATOM_W*LANES-1:0] data;
    logic [LANES-1:0]        mask;
    logic                    last;
  } pdp_wdma_beat_t;

endpackage

// File: rtl/nv_nvdla_pdp_wdma_cube_cnt.sv
// Output-cube position tracker: shadow config plus w/h/surface counters,
// flags the final atom of the layer.
module nv_nvdla_pdp_wdma_cube_cnt (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        start,
  input  logic        adv,
  input  logic [12:0] cfg_width,
  input  logic [12:0] cfg_height,
  input  logic [9:0]  cfg_surf,
  output logic        is_last_atom
);

  logic [12:0] width_sh;
  logic [12:0] height_sh;
  logic [9:0]  surf_sh;
  logic [12:0] w_cnt;
  logic [12:0] h_cnt;
  logic [9:0]  s_cnt;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      width_sh  <= '0;
      height_sh <= '0;
      surf_sh   <= '0;
      w_cnt     <= '0;
      h_cnt     <= '0;
      s_cnt     <= '0;
    end else if (start) begin
      width_sh  <= cfg_width;
      height_sh <= cfg_height;
      surf_sh   <= cfg_surf;
      w_cnt     <= '0;
      h_cnt     <= '0;
      s_cnt     <= '0;
    end else if (adv) begin
      // w fastest, then h, then surface
      if (w_cnt == width_sh) begin
        w_cnt <= '0;
        if (h_cnt == height_sh) begin
          h_cnt <= '0;
          s_cnt <= s_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 13'd1;
        end
      end else begin
        w_cnt <= w_cnt + 13'd1;
      end
    end
  end

  assign is_last_atom = (w_cnt == width_sh) && (h_cnt == height_sh) && (s_cnt == surf_sh);

endmodule

// File: rtl/nv_nvdla_pdp_wdma_dat_pack.sv
// PDP write-DMA data packer: gathers LANES pooled atoms into one masked
// write-data beat, flushes the partial final beat and pulses layer done.
//
// state    | meaning
// ST_IDLE  | waiting for op_en rising edge
// ST_RUN   | accepting atoms and packing beats
// ST_DRAIN | last atom taken, waiting for the last beat to handshake
// ST_DONE  | one-cycle dp2reg_done pulse
module nv_nvdla_pdp_wdma_dat_pack #(
  parameter int ATOM_W = 64,
  parameter int LANES  = 4
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  input  logic                    reg2dp_op_en,
  input  logic [12:0]             reg2dp_cube_out_width,
  input  logic [12:0]             reg2dp_cube_out_height,
  input  logic [12:0]             reg2dp_cube_out_channel,
  input  logic                    pdp_dp2wdma_valid,
  output logic                    pdp_dp2wdma_ready,
  input  logic [ATOM_W-1:0]       pdp_dp2wdma_pd,
  output logic                    dma_wr_dat_valid,
  input  logic                    dma_wr_dat_ready,
  output logic [ATOM_W*LANES-1:0] dma_wr_dat_data,
  output logic [LANES-1:0]        dma_wr_dat_mask,
  output logic                    dma_wr_dat_last,
  output logic                    dp2reg_done
);
  import nv_nvdla_pdp_pkg::*;

  localparam int LANE_W = $clog2(LANES);
  localparam int BEAT_W = ATOM_W * LANES;

  pdp_wdma_pack_state_e state, state_nxt;
  logic                 op_en_d;
  logic [LANE_W-1:0]    lane_idx;
  logic [BEAT_W-1:0]    pack_data, pack_data_nxt;
  logic [LANES-1:0]     pack_mask, pack_mask_nxt;
  pdp_wdma_beat_t       out_beat;
  logic                 out_valid;
  logic                 start;
  logic                 is_last_atom;
  logic                 completes;
  logic                 atom_acc;
  logic                 beat_acc;
  logic                 unused_cfg;

  assign unused_cfg = ^reg2dp_cube_out_channel[2:0];

  assign start     = (state == ST_IDLE) && reg2dp_op_en && !op_en_d;
  assign completes = (lane_idx == LANE_W'(LANES - 1)) || is_last_atom;
  // completing atom may only enter when the output slot is free or draining now
  assign pdp_dp2wdma_ready = (state == ST_RUN) && (!completes || !out_valid || dma_wr_dat_ready);
  assign atom_acc  = pdp_dp2wdma_valid && pdp_dp2wdma_ready;
  assign beat_acc  = out_valid && dma_wr_dat_ready;

  nv_nvdla_pdp_wdma_cube_cnt u_cube_cnt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .start           (start),
    .adv             (atom_acc),
    .cfg_width       (reg2dp_cube_out_width),
    .cfg_height      (reg2dp_cube_out_height),
    .cfg_surf        (reg2dp_cube_out_channel[12:3]),
    .is_last_atom    (is_last_atom)
  );

  always_comb begin
    pack_data_nxt = pack_data;
    pack_mask_nxt = pack_mask;
    pack_data_nxt[lane_idx*ATOM_W +: ATOM_W] = pdp_dp2wdma_pd;
    pack_mask_nxt[lane_idx] = 1'b1;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en_d   <= 1'b0;
      lane_idx  <= '0;
      pack_data <= '0;
      pack_mask <= '0;
    end else begin
      op_en_d <= reg2dp_op_en;
      if (start || (atom_acc && completes)) begin
        lane_idx  <= '0;
        pack_data <= '0;
        pack_mask <= '0;
      end else if (atom_acc) begin
        lane_idx  <= lane_idx + LANE_W'(1);
        pack_data <= pack_data_nxt;
        pack_mask <= pack_mask_nxt;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (atom_acc && completes) begin
      out_valid     <= 1'b1;
      out_beat.data <= pack_data_nxt;
      out_beat.mask <= pack_mask_nxt;
      out_beat.last <= is_last_atom;
    end else if (beat_acc) begin
      out_valid <= 1'b0;
    end
  end

  assign dma_wr_dat_valid = out_valid;
  assign dma_wr_dat_data  = out_beat.data;
  assign dma_wr_dat_mask  = out_beat.mask;
  assign dma_wr_dat_last  = out_beat.last;
  assign dp2reg_done      = (state == ST_DONE);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) state <= ST_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (atom_acc && is_last_atom) state_nxt = ST_DRAIN;
      ST_DRAIN: if (beat_acc && out_beat.last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

endmodule
